fp_div_iter: RTL and testbench
==============================

// Module: fp_div_iter
// PURPOSE
// Parametrised iterative IEEE-754 divider, generalised in EXP_W/MAN_W, with valid/ready handshakes on both sides.
// Computes in1/in2 with a one-bit-per-cycle restoring mantissa divider and round-to-nearest-even.
// Special operands (zero/inf/NaN) bypass the divider and resolve in one cycle.
// Sits in the FP datapath between operand registers and the result writeback stage.
// PARAMETERS
// EXP_W  8   exponent width; BIAS = 2**(EXP_W-1)-1
// MAN_W  23  stored mantissa width; W = 1+EXP_W+MAN_W (32 by default)
// PORTS
// clk        in   1  clock, all state on rising edge
// rst_n      in   1  synchronous active-low reset
// in_valid   in   1  operands present
// in_ready   out  1  block can accept (high only in IDLE)
// in1        in   W  dividend
// in2        in   W  divisor
// out_valid  out  1  result present; held until out_ready
// out_ready  in   1  consumer accepts result
// result     out  W  quotient, stable while out_valid
// busy       out  1  state != IDLE
// BEHAVIOUR
// - Reset (rst_n=0 at edge): state IDLE, out_valid=0, result=0, busy=0, counter=0; in_ready=1 after reset.
//   Reset mid-DIVIDE or in DONE aborts: the pending result is discarded, not emitted.
// - Classification: zero = exp==0 (subnormals flushed to zero); inf = exp all-1, man==0; NaN = exp all-1, man!=0.
// - Accept: in_valid&&in_ready at edge latches in1/in2; sign = in1.s ^ in2.s.
// - States: IDLE -> DONE if either operand special; IDLE -> DIVIDE otherwise;
//   DIVIDE -> NORM after MAN_W+3 iterations; NORM -> DONE; DONE -> IDLE on out_ready.
// - Special table (a/b), QNAN = {0,all-1 exp,all-1 man} (0x7FFFFFFF default):
//   NaN in either -> QNAN; 0/0 -> QNAN; inf/inf -> QNAN;
//   0/inf, 0/x, x/inf -> +0 (all-zero word, sign dropped);
//   inf/0, inf/x, x/0 -> {sign, all-1 exp, 0 man}.
// - Divide: mantissas 1.ma, 1.mb (MAN_W+1 bits); restoring shift-subtract, one quotient bit/cycle,
//   MAN_W+3 bits total (covers normalise bit + guard + round); sticky = final remainder != 0.
// - NORM (one cycle): if quotient MSB=0, shift left 1 and exp-1. RNE on guard/round/sticky.
//   Mantissa carry-out after rounding: shift right and exp+1.
//   Exponent computed signed in EXP_W+2 bits: e = ea - eb + BIAS.
//   e >= 2**EXP_W-1 -> {sign, inf}; e <= 0 -> +0 (flush to zero, no subnormal output).
// - Latency: special -> out_valid high the cycle after accept; normal -> out_valid high MAN_W+4 cycles after accept (27 default).
// - Output: result/out_valid registered; both held unchanged while out_valid && !out_ready.
//   Leaving DONE clears out_valid. in_ready rises the cycle after, so no back-to-back accept on the hand-off edge.
// - in_valid while busy is ignored (in_ready=0); operands are never re-sampled mid-operation.
// - No X on result/out_valid after reset regardless of input values.
// TESTING
// 1. in1=0x40C00000 (6.0), in2=0x40000000 (2.0) -> result 0x40400000, out_valid exactly 27 cycles after accept.
// 2. 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAB (RNE rounds up); 0xBF800000 / 0x40400000 -> 0xBEAAAAAB.
// 3. Specials, each valid 1 cycle after accept:
//    0/0 -> 0x7FFFFFFF; 0xC0A00000/0 -> 0xFF800000; 0x3F800000/0x7F800000 -> 0x00000000;
//    0x7F800000/0x7F800000 -> 0x7FFFFFFF; 0x7FC00000/x -> 0x7FFFFFFF.
// 4. Range: 0x7F000000 / 0x3E800000 -> 0x7F800000 (overflow); 0x00800000 / 0x40000000 -> 0x00000000 (underflow flush).
// 5. Backpressure: out_ready=0 for 10 cycles after 6/2 -> result 0x40400000 held, in_ready=0;
//    out_ready=1 -> in_ready=1 next cycle, second op accepted.
// 6. Reset: rst_n=0 at cycle 10 of a divide -> next cycle out_valid=0, in_ready=1, busy=0; the aborted result never appears.
//    Repeat at MAN_W=10, EXP_W=5: 0x4600/0x4000 (6/2) -> 0x4200.

Source files
------------

// File: rtl/fp_div_iter.sv
// Iterative IEEE-754 divider: one restoring quotient bit per cycle, RNE rounding,
// flush-to-zero for subnormals. Zero, inf and NaN operands resolve in one cycle without dividing.
module fp_div_iter #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [EXP_W+MAN_W:0] in1,
   input  logic [EXP_W+MAN_W:0] in2,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [EXP_W+MAN_W:0] result,
   output logic                 busy
);
   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int EW = EXP_W + 2;
   localparam int QW = MAN_W + 3;
   localparam int CW = $clog2(QW);
   localparam logic signed [EW-1:0] BIAS = EW'((2 ** (EXP_W - 1)) - 1);
   localparam logic signed [EW-1:0] EMAX = EW'((2 ** EXP_W) - 1);
   localparam logic [W-1:0]         QNAN = {1'b0, {(EXP_W + MAN_W){1'b1}}};

   typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_NORM, S_DONE} state_t;

   state_t                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [MAN_W+1:0]       rem_q, rem_d;
   logic [MAN_W:0]         div_q, div_d;
   logic [QW-1:0]          quo_q, quo_d;
   logic signed [EW-1:0]   exp_q, exp_d;
   logic                   sign_q, sign_d;
   logic [W-1:0]           res_q, res_d;
   logic                   ovld_q, ovld_d;

   logic [EXP_W-1:0]       a_exp, b_exp;
   logic [MAN_W-1:0]       a_man, b_man;
   logic                   a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, special;
   logic                   in_sign;
   logic [W-1:0]           spec_res;
   logic signed [EW-1:0]   exp_init;

   assign a_exp   = in1[W-2:MAN_W];
   assign b_exp   = in2[W-2:MAN_W];
   assign a_man   = in1[MAN_W-1:0];
   assign b_man   = in2[MAN_W-1:0];
   assign in_sign = in1[W-1] ^ in2[W-1];
   assign a_zero  = (a_exp == '0);
   assign b_zero  = (b_exp == '0);
   assign a_inf   = (&a_exp) && (a_man == '0);
   assign b_inf   = (&b_exp) && (b_man == '0);
   assign a_nan   = (&a_exp) && (a_man != '0);
   assign b_nan   = (&b_exp) && (b_man != '0);
   assign special = a_zero | a_inf | a_nan | b_zero | b_inf | b_nan;
   assign exp_init = $signed({2'b00, a_exp}) - $signed({2'b00, b_exp}) + BIAS;

   always_comb begin
      spec_res = {in_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
         spec_res = QNAN;
      else if (a_zero || b_inf)
         spec_res = '0;
   end

   // Restoring step: remainder stays below twice the divisor, so MAN_W+2 bits suffice.
   logic                   ge;
   logic [MAN_W+1:0]       diff, rem_nxt;
   assign ge      = (rem_q >= {1'b0, div_q});
   assign diff    = rem_q - {1'b0, div_q};
   assign rem_nxt = ge ? {diff[MAN_W:0], 1'b0} : {rem_q[MAN_W:0], 1'b0};

   logic                   msb, g_bit, r_bit, s_bit, rnd_up, carry;
   logic [MAN_W:0]         sig;
   logic [MAN_W+1:0]       sig_r;
   logic [MAN_W-1:0]       man_n;
   logic signed [EW-1:0]   exp_n;
   logic [W-1:0]           norm_res;

   always_comb begin
      msb    = quo_q[QW-1];
      sig    = msb ? quo_q[QW-1:2] : quo_q[QW-2:1];
      g_bit  = msb ? quo_q[1] : quo_q[0];
      r_bit  = msb ? quo_q[0] : 1'b0;
      s_bit  = (rem_q != '0);
      rnd_up = g_bit & (r_bit | s_bit | sig[0]);
      sig_r  = {1'b0, sig} + {{(MAN_W + 1){1'b0}}, rnd_up};
      carry  = sig_r[MAN_W+1];
      man_n  = carry ? sig_r[MAN_W:1] : sig_r[MAN_W-1:0];
      exp_n  = exp_q - {{(EW - 1){1'b0}}, ~msb} + {{(EW - 1){1'b0}}, carry};
      if (!exp_n[EW-1] && exp_n >= EMAX)
         norm_res = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      else if (exp_n[EW-1] || exp_n == '0)
         norm_res = '0;
      else
         norm_res = {sign_q, exp_n[EXP_W-1:0], man_n};
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      div_d   = div_q;
      quo_d   = quo_q;
      exp_d   = exp_q;
      sign_d  = sign_q;
      res_d   = res_q;
      ovld_d  = ovld_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               sign_d = in_sign;
               if (special) begin
                  res_d   = spec_res;
                  ovld_d  = 1'b1;
                  state_d = S_DONE;
               end else begin
                  rem_d   = {2'b01, a_man};
                  div_d   = {1'b1, b_man};
                  quo_d   = '0;
                  cnt_d   = '0;
                  exp_d   = exp_init;
                  state_d = S_DIVIDE;
               end
            end
         end
         S_DIVIDE: begin
            rem_d = rem_nxt;
            quo_d = {quo_q[QW-2:0], ge};
            if (cnt_q == CW'(QW - 1)) begin
               cnt_d   = '0;
               state_d = S_NORM;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_NORM: begin
            res_d   = norm_res;
            ovld_d  = 1'b1;
            state_d = S_DONE;
         end
         S_DONE: begin
            if (out_ready) begin
               ovld_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         div_q   <= '0;
         quo_q   <= '0;
         exp_q   <= '0;
         sign_q  <= 1'b0;
         res_q   <= '0;
         ovld_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         div_q   <= div_d;
         quo_q   <= quo_d;
         exp_q   <= exp_d;
         sign_q  <= sign_d;
         res_q   <= res_d;
         ovld_q  <= ovld_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign out_valid = ovld_q;
   assign result    = res_q;
endmodule

// File: tb/tb_fp_div_iter.sv
// Bench for fp_div_iter: directed cases plus random operands checked against an
// exact integer long-division RNE model, on a binary32 and a 16-bit instance.
module tb_fp_div_iter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        iv32 = 0, ir32, ov32, or32 = 1, b32;
   logic [31:0] a32 = 0, bb32 = 0, r32;
   logic        iv16 = 0, ir16, ov16, or16 = 1, b16;
   logic [15:0] a16 = 0, bb16 = 0, r16;

   fp_div_iter dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .in1(a32), .in2(bb32),
      .out_valid(ov32), .out_ready(or32), .result(r32), .busy(b32));

   fp_div_iter #(.EXP_W(5), .MAN_W(10)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .in1(a16), .in2(bb16),
      .out_valid(ov16), .out_ready(or16), .result(r16), .busy(b16));

   int checks = 0;
   int errors = 0;

   task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int ew_of(int d); return (d == 0) ? 8 : 5; endfunction
   function automatic int mw_of(int d); return (d == 0) ? 23 : 10; endfunction
   function automatic logic rdy(int d); return (d == 0) ? ir32 : ir16; endfunction
   function automatic logic vld(int d); return (d == 0) ? ov32 : ov16; endfunction
   function automatic logic bsy(int d); return (d == 0) ? b32 : b16; endfunction
   function automatic logic [31:0] res_of(int d); return (d == 0) ? r32 : {16'h0, r16}; endfunction

   task automatic drive(int d, logic v, logic [31:0] a, logic [31:0] b);
      if (d == 0) begin iv32 = v; a32 = a; bb32 = b; end
      else begin iv16 = v; a16 = a[15:0]; bb16 = b[15:0]; end
   endtask

   function automatic bit is_special(logic [31:0] x, int ew, int mw);
      longint e;
      e = (longint'(x) >> mw) & ((longint'(1) << ew) - 1);
      return (e == 0) || (e == (longint'(1) << ew) - 1);
   endfunction

   // Exact quotient scaled by 2^(mw+3); drop 2 or 3 bits depending on normalisation, round to nearest even.
   function automatic logic [31:0] ref_div(logic [31:0] a, logic [31:0] b, int ew, int mw);
      longint one, emask, mmask, ea, eb, ma, mb, sgn, qnan, inf, fa, fb, num, q, rm, e;
      longint drop, d, half, sig, up;
      bit az, ai, an, bz, bi, bn;
      one   = 1;
      emask = (one << ew) - 1;
      mmask = (one << mw) - 1;
      ea = (longint'(a) >> mw) & emask;  eb = (longint'(b) >> mw) & emask;
      ma = longint'(a) & mmask;          mb = longint'(b) & mmask;
      sgn = ((longint'(a) ^ longint'(b)) >> (ew + mw)) & 1;
      qnan = (one << (ew + mw)) - 1;
      inf  = (sgn << (ew + mw)) | (emask << mw);
      az = (ea == 0); ai = (ea == emask) && (ma == 0); an = (ea == emask) && (ma != 0);
      bz = (eb == 0); bi = (eb == emask) && (mb == 0); bn = (eb == emask) && (mb != 0);
      if (an || bn || (az && bz) || (ai && bi)) return 32'(qnan);
      if (az || bi) return 32'h0;
      if (ai || bz) return 32'(inf);
      fa  = (one << mw) | ma;
      fb  = (one << mw) | mb;
      num = fa << (mw + 3);
      q   = num / fb;
      rm  = num % fb;
      e   = ea - eb + ((one << (ew - 1)) - 1);
      if (q >= (one << (mw + 3))) drop = 3;
      else begin drop = 2; e = e - 1; end
      d    = q & ((one << drop) - 1);
      half = one << (drop - 1);
      sig  = q >> drop;
      up   = ((d > half) || (d == half && rm != 0) || (d == half && rm == 0 && (sig & 1) == 1)) ? 1 : 0;
      sig  = sig + up;
      if (sig == (one << (mw + 1))) begin sig = sig >> 1; e = e + 1; end
      if (e >= emask) return 32'(inf);
      if (e <= 0) return 32'h0;
      return 32'((sgn << (ew + mw)) | (e << mw) | (sig & mmask));
   endfunction

   function automatic logic [31:0] rand_op(int ew, int mw);
      longint emask, e, m, s;
      int sel;
      emask = (longint'(1) << ew) - 1;
      sel = int'($urandom_range(0, 9));
      s = longint'($urandom_range(0, 1));
      if (sel == 0) e = 0;
      else if (sel == 1) e = emask;
      else e = longint'($urandom_range(1, 32'(emask - 1)));
      m = (sel == 2) ? 0 : (longint'($urandom) & ((longint'(1) << mw) - 1));
      return 32'((s << (ew + mw)) | (e << mw) | m);
   endfunction

   task automatic start(int d, logic [31:0] a, logic [31:0] b);
      @(negedge clk);
      drive(d, 1'b1, a, b);
      check("in_ready_idle", rdy(d), 1);
      @(posedge clk); #1;
      drive(d, 1'b0, a, b);
      check("busy_after_accept", bsy(d), 1);
   endtask

   // Latency counts edges after the accepting edge; specials are visible right after it.
   task automatic wait_res(int d, string tag, int exp_lat, output logic [31:0] res);
      int lat;
      lat = 0;
      while (vld(d) !== 1'b1 && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "_lat"}, lat, exp_lat);
      res = res_of(d);
   endtask

   task automatic handoff(int d);
      @(posedge clk); #1;
      check("handoff_valid", vld(d), 0);
      check("handoff_ready", rdy(d), 1);
      check("handoff_busy", bsy(d), 0);
   endtask

   task automatic op(int d, logic [31:0] a, logic [31:0] b, logic [31:0] exp, string tag);
      logic [31:0] r;
      int lat;
      lat = is_special(a, ew_of(d), mw_of(d)) || is_special(b, ew_of(d), mw_of(d)) ? 0 : mw_of(d) + 4;
      start(d, a, b);
      wait_res(d, tag, lat, r);
      check(tag, r, exp);
      handoff(d);
   endtask

   task automatic reset_state(string tag);
      check({tag, "_ov32"}, ov32, 0); check({tag, "_rdy32"}, ir32, 1);
      check({tag, "_busy32"}, b32, 0); check({tag, "_res32"}, r32, 0);
      check({tag, "_ov16"}, ov16, 0); check({tag, "_rdy16"}, ir16, 1);
      check({tag, "_busy16"}, b16, 0); check({tag, "_res16"}, r16, 0);
   endtask

   initial begin
      logic [31:0] r, a, b;
      int seen;

      repeat (3) @(posedge clk);
      #1;
      reset_state("reset");
      rst_n = 1'b1;

      op(0, 32'h40C00000, 32'h40000000, 32'h40400000, "six_div_two");
      op(0, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, "one_third");
      op(0, 32'hBF800000, 32'h40400000, 32'hBEAAAAAB, "neg_one_third");

      op(0, 32'h00000000, 32'h00000000, 32'h7FFFFFFF, "zero_zero");
      op(0, 32'hC0A00000, 32'h00000000, 32'hFF800000, "x_div_zero");
      op(0, 32'h3F800000, 32'h7F800000, 32'h00000000, "x_div_inf");
      op(0, 32'h7F800000, 32'h7F800000, 32'h7FFFFFFF, "inf_inf");
      op(0, 32'h7FC00000, 32'h40000000, 32'h7FFFFFFF, "nan_in");

      op(0, 32'h7F000000, 32'h3E800000, 32'h7F800000, "overflow");
      op(0, 32'h00800000, 32'h40000000, 32'h00000000, "underflow");

      // Backpressure: result held, new operands ignored until the hand-off.
      or32 = 1'b0;
      start(0, 32'h40C00000, 32'h40000000);
      wait_res(0, "bp", 27, r);
      check("bp_res", r, 32'h40400000);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         drive(0, 1'b1, 32'h3F800000, 32'h40400000);
         @(posedge clk); #1;
         check("bp_hold_valid", ov32, 1);
         check("bp_hold_res", r32, 32'h40400000);
         check("bp_hold_ready", ir32, 0);
      end
      or32 = 1'b1;
      @(posedge clk); #1;
      check("bp_release_valid", ov32, 0);
      check("bp_release_ready", ir32, 1);
      @(posedge clk); #1;
      drive(0, 1'b0, 32'h3F800000, 32'h40400000);
      check("bp_second_accept", b32, 1);
      wait_res(0, "bp2", 27, r);
      check("bp2_res", r, 32'h3EAAAAAB);
      handoff(0);

      // Reset in the middle of a divide discards the pending result.
      start(0, 32'h40C00000, 32'h40000000);
      repeat (9) @(posedge clk);
      @(negedge clk) rst_n = 1'b0;
      @(posedge clk); #1;
      reset_state("abort");
      rst_n = 1'b1;
      seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (ov32 !== 1'b0) seen++;
      end
      check("abort_no_result", seen, 0);

      op(1, 32'h4600, 32'h4000, 32'h4200, "h_six_div_two");
      start(1, 32'h4600, 32'h4000);
      repeat (5) @(posedge clk);
      @(negedge clk) rst_n = 1'b0;
      @(posedge clk); #1;
      reset_state("h_abort");
      rst_n = 1'b1;
      seen = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (ov16 !== 1'b0) seen++;
      end
      check("h_abort_no_result", seen, 0);
      op(1, 32'h4600, 32'h4000, 32'h4200, "h_after_abort");

      for (int i = 0; i < 30; i++) begin
         a = rand_op(8, 23);
         b = rand_op(8, 23);
         op(0, a, b, ref_div(a, b, 8, 23), "rand32");
      end
      for (int i = 0; i < 15; i++) begin
         a = rand_op(5, 10);
         b = rand_op(5, 10);
         op(1, a, b, ref_div(a, b, 5, 10), "rand16");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
